// File: rtl/dut_conv_pkg.sv
// LeNet5 conv accumulator: shared constants, FSM states, saturation helper.
// Rounding is enabled by defining DUT_CONV_ACC_ROUND_EN.
package dut_conv_pkg;

  localparam int PROD_WIDTH = 22;
  localparam int ACC_WIDTH  = 32;
  localparam int KERNEL_LEN = 25;
  localparam int SHIFT      = 8;
  localparam int OUT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  // Largest value representable in w output bits, sized to the shifted sum.
  function automatic logic [ACC_WIDTH:0] sat_max(input int w);
    return ~({(ACC_WIDTH + 1){1'b1}} << w);
  endfunction

endpackage

// File: rtl/dut_conv_acc_rescale.sv
// Rescale stage: optional round, right shift, saturate to OUT_WIDTH.
// Rounding is enabled by defining DUT_CONV_ACC_ROUND_EN.
module dut_conv_rescale
  import dut_conv_pkg::*;
#(
  parameter int ACC_W   = dut_conv_pkg::ACC_WIDTH,
  parameter int OUT_W   = dut_conv_pkg::OUT_WIDTH,
  parameter int SHIFT_W = dut_conv_pkg::SHIFT
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] pix_o
);

  localparam logic [ACC_W:0] MAX =
    (ACC_W + 1)'(sat_max(OUT_W));

  logic [ACC_W:0] ext;
  logic [ACC_W:0] r;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    ext = {1'b0, acc_i};
`ifdef DUT_CONV_ACC_ROUND_EN
    ext = ext + ((ACC_W + 1)'(1) << (SHIFT_W - 1));
`else
    ext = ext;
`endif
    r = ext >> SHIFT_W;
    if (r > MAX) begin
      pix_o = '1;
    end else begin
      pix_o = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dut_conv_acc.sv
// Conv window accumulator: sum KERNEL_LEN products + bias, rescale, emit.
// Rounding is enabled by defining DUT_CONV_ACC_ROUND_EN.
module dut_conv_acc
  import dut_conv_pkg::*;
#(
  parameter int PROD_WIDTH = dut_conv_pkg::PROD_WIDTH,
  parameter int ACC_WIDTH  = dut_conv_pkg::ACC_WIDTH,
  parameter int KERNEL_LEN = dut_conv_pkg::KERNEL_LEN,
  parameter int SHIFT      = dut_conv_pkg::SHIFT,
  parameter int OUT_WIDTH  = dut_conv_pkg::OUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_len
);

  localparam int CNT_W = $clog2(KERNEL_LEN + 1);

  if (ACC_WIDTH < PROD_WIDTH + $clog2(KERNEL_LEN) + 1)
  begin : g_bad_acc
    $error("ACC_WIDTH too small for KERNEL_LEN products");
  end
  if (SHIFT < 1 || SHIFT > ACC_WIDTH - 1)
  begin : g_bad_shift
    $error("SHIFT out of range");
  end

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 last_beat;
  logic [ACC_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0] pix;

  assign prod_ready = (state_q != ST_OUTPUT) && !ap_rst;
  assign accept     = prod_valid && prod_ready;
  assign last_beat  = cnt_q == CNT_W'(KERNEL_LEN - 1);

  // First beat of a window seeds the sum with the bias.
  assign sum = ((state_q == ST_IDLE) ? bias : acc_q)
             + ACC_WIDTH'(prod_data);

  dut_conv_rescale #(
    .ACC_W   (ACC_WIDTH),
    .OUT_W   (OUT_WIDTH),
    .SHIFT_W (SHIFT)
  ) u_rescale (
    .acc_i (sum),
    .pix_o (pix)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (prod_last != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            out_d   = pix;
            state_d = ST_OUTPUT;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = state_q == ST_OUTPUT;
  assign out_data  = out_q;
  assign err_len   = err_q;

endmodule
